// File: rtl/state_sequencer.sv
// Brain-state sequencer: accepts state-change requests and holds each new state
// for a minimum dwell time. A force_normal abort overrides everything.
module state_sequencer #(
  parameter int               CNT_W       = 16,
  parameter logic [CNT_W-1:0] DWELL_TICKS = 16'd4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       req_valid,
  input  logic [2:0] req_state,
  output logic       req_ready,
  input  logic       force_normal,
  output logic [2:0] state_select,
  output logic [2:0] prev_state,
  output logic       transition_pulse,
  output logic       reject_pulse,
  output logic       busy,
  output logic [7:0] transition_count,
  output logic [7:0] reject_count
);

  localparam logic IDLE  = 1'b0;
  localparam logic DWELL = 1'b1;

  logic             fsm;
  logic [CNT_W-1:0] counter;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign req_ready = (fsm == IDLE) && !force_normal && !rst;
  assign busy      = (fsm == DWELL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm              <= IDLE;
      counter          <= '0;
      state_select     <= 3'd0;
      prev_state       <= 3'd0;
      transition_pulse <= 1'b0;
      reject_pulse     <= 1'b0;
      transition_count <= 8'd0;
      reject_count     <= 8'd0;
    end else begin
      transition_pulse <= 1'b0;
      reject_pulse     <= 1'b0;
      if (force_normal) begin
        // Abort: only a real change away from NORMAL counts as a transition
        state_select <= 3'd0;
        counter      <= '0;
        fsm          <= IDLE;
        if (state_select != 3'd0) begin
          prev_state       <= state_select;
          transition_pulse <= 1'b1;
          transition_count <= sat_inc(transition_count);
        end
      end else if (fsm == IDLE) begin
        if (req_valid) begin
          if (req_state > 3'd4) begin
            reject_pulse <= 1'b1;
            reject_count <= sat_inc(reject_count);
          end else if (req_state != state_select) begin
            state_select     <= req_state;
            prev_state       <= state_select;
            transition_pulse <= 1'b1;
            transition_count <= sat_inc(transition_count);
            if (DWELL_TICKS != '0) begin
              counter <= DWELL_TICKS;
              fsm     <= DWELL;
            end
          end
        end
      end else if (clk_en) begin
        // Leaving on the tick where counter reaches 1 gives exactly DWELL_TICKS ticks
        if (counter <= CNT_W'(1)) begin
          counter <= '0;
          fsm     <= IDLE;
        end else begin
          counter <= counter - CNT_W'(1);
        end
      end
    end
  end

endmodule
